// File: rtl/i2c_target.sv
// I2C target (slave) with a fixed 7-bit address: receives write bytes on rx_data/rx_valid
// and serves read bytes from tx_data, requested one byte ahead with tx_req.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    logic [1:0] r_sclSync;
    logic [1:0] r_sdaSync;
    logic       r_sclPrev;
    logic       r_sdaPrev;

    state_t     r_state;
    logic [2:0] r_bitCnt;
    logic [6:0] r_shift;
    logic       r_rw;
    logic       r_ackPhase;
    logic [7:0] r_txShift;

    logic       w_scl;
    logic       w_sda;
    logic       w_sclRise;
    logic       w_sclFall;
    logic       w_start;
    logic       w_stop;
    logic       w_lastBit;
    logic       w_addrMatch;

    // Synchronizers and edge history reset to 1 so an idle bus shows no edges after reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_sclSync <= 2'b11;
            r_sdaSync <= 2'b11;
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclSync <= {r_sclSync[0], scl_in};
            r_sdaSync <= {r_sdaSync[0], sda_in};
            r_sclPrev <= r_sclSync[1];
            r_sdaPrev <= r_sdaSync[1];
        end
    end

    assign w_scl       = r_sclSync[1];
    assign w_sda       = r_sdaSync[1];
    assign w_sclRise   = w_scl & ~r_sclPrev;
    assign w_sclFall   = ~w_scl & r_sclPrev;
    assign w_start     = w_scl & r_sclPrev & r_sdaPrev & ~w_sda;
    assign w_stop      = w_scl & r_sclPrev & ~r_sdaPrev & w_sda;
    assign w_lastBit   = (r_bitCnt == 3'd7);
    assign w_addrMatch = (r_shift == TARGET_ADDR);

    // r_ackPhase marks the second half of an ACK slot: set once the ACK bit is being driven
    // (write side) or once the controller's ACK has been seen (read side).
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state    <= IDLE;
            r_bitCnt   <= 3'd0;
            r_shift    <= 7'd0;
            r_rw       <= 1'b0;
            r_ackPhase <= 1'b0;
            r_txShift  <= 8'h00;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (w_start) begin
                r_state    <= ADDR;
                r_bitCnt   <= 3'd0;
                r_ackPhase <= 1'b0;
                sda_oe     <= 1'b0;
                busy       <= 1'b1;
            end else if (w_stop) begin
                r_state    <= IDLE;
                r_bitCnt   <= 3'd0;
                r_ackPhase <= 1'b0;
                sda_oe     <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: begin
                        if (w_sclRise) begin
                            r_shift  <= {r_shift[5:0], w_sda};
                            r_bitCnt <= r_bitCnt + 3'd1;
                            if (w_lastBit) begin
                                r_ackPhase <= 1'b0;
                                r_rw       <= w_sda;
                                r_state    <= w_addrMatch ? ADDR_ACK : WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (w_sclFall) begin
                            if (!r_ackPhase) begin
                                sda_oe     <= 1'b1;
                                r_ackPhase <= 1'b1;
                            end else if (r_rw) begin
                                r_txShift  <= tx_data;
                                sda_oe     <= ~tx_data[7];
                                r_ackPhase <= 1'b0;
                                r_state    <= RD_DATA;
                            end else begin
                                sda_oe     <= 1'b0;
                                r_ackPhase <= 1'b0;
                                r_state    <= WR_DATA;
                            end
                        end else if (w_sclRise && r_ackPhase && r_rw) begin
                            tx_req <= 1'b1;
                        end
                    end
                    WR_DATA: begin
                        if (w_sclRise) begin
                            r_shift  <= {r_shift[5:0], w_sda};
                            r_bitCnt <= r_bitCnt + 3'd1;
                            if (w_lastBit) begin
                                rx_data    <= {r_shift, w_sda};
                                rx_valid   <= 1'b1;
                                r_ackPhase <= 1'b0;
                                r_state    <= WR_ACK;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (w_sclFall) begin
                            if (!r_ackPhase) begin
                                sda_oe     <= 1'b1;
                                r_ackPhase <= 1'b1;
                            end else begin
                                sda_oe     <= 1'b0;
                                r_ackPhase <= 1'b0;
                                r_state    <= WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (w_sclRise) begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                            if (w_lastBit) begin
                                r_ackPhase <= 1'b0;
                                r_state    <= RD_ACK;
                            end
                        end else if (w_sclFall) begin
                            sda_oe <= ~r_txShift[3'd7 - r_bitCnt];
                        end
                    end
                    RD_ACK: begin
                        if (w_sclFall) begin
                            if (r_ackPhase) begin
                                r_txShift  <= tx_data;
                                sda_oe     <= ~tx_data[7];
                                r_ackPhase <= 1'b0;
                                r_state    <= RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end else if (w_sclRise) begin
                            if (!w_sda) begin
                                tx_req     <= 1'b1;
                                r_ackPhase <= 1'b1;
                            end else begin
                                r_state <= WAIT_STOP;
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-banged bus controller drives directed and
// randomized transfers, and a transaction-level model predicts ACKs, bytes and pulse counts.
module tb_i2c_target;

    localparam logic [6:0] DUT_ADDR = 7'h50;
    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       ctrlScl = 1'b1;
    logic       ctrlSda = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sdaLine;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int rxCount = 0;
    int txReqCount = 0;
    int oeCount = 0;
    int busyFallCount = 0;
    logic busyPrev = 1'b0;
    logic [7:0] rxLog[$];
    logic [7:0] modelRx = 8'h00;

    assign sdaLine = ctrlSda & ~sda_oe;

    i2c_target #(.TARGET_ADDR(DUT_ADDR)) dut (
        .clk(clk),
        .rst_(rst_),
        .scl_in(ctrlScl),
        .sda_in(sdaLine),
        .sda_oe(sda_oe),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_req(tx_req),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse, drive and busy-edge bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid) begin
            rxCount++;
            rxLog.push_back(rx_data);
        end
        if (tx_req) txReqCount++;
        if (sda_oe) oeCount++;
        if (busyPrev && !busy) busyFallCount++;
        busyPrev = busy;
    end

    initial begin
        #900000;
        $display("[TB] FAIL timeout reached actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic busStart();
        ctrlSda = 1'b1; #Q;
        ctrlScl = 1'b1; #Q;
        ctrlSda = 1'b0; #Q;
        ctrlScl = 1'b0; #Q;
    endtask

    task automatic busStop();
        ctrlSda = 1'b0; #Q;
        ctrlScl = 1'b1; #Q;
        ctrlSda = 1'b1; #Q;
    endtask

    task automatic writeBit(input logic b);
        ctrlSda = b; #Q;
        ctrlScl = 1'b1; #(2 * Q);
        ctrlScl = 1'b0; #Q;
    endtask

    task automatic readBit(output logic b);
        ctrlSda = 1'b1; #Q;
        ctrlScl = 1'b1; #Q;
        b = sdaLine; #Q;
        ctrlScl = 1'b0; #Q;
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        readBit(ack);
    endtask

    task automatic readByte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            d[i] = b;
        end
        writeBit(ack);
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_sda_oe actual=%b required=0", sda_oe); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data actual=%h required=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_valid actual=%b required=0", rx_valid); end
        checks++; if (tx_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_req actual=%b required=0", tx_req); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b required=0", busy); end
        rst_ = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0 || sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle actual=busy%b/oe%b required=0/0", busy, sda_oe); end
    endtask

    task automatic test_write();
        logic ack;
        int rx0 = rxCount;
        busStart();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL write_busy_set actual=%b required=1", busy); end
        writeByte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL write_addr_ack actual=%b required=0", ack); end
        writeByte(8'h3C, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL write_data_ack actual=%b required=0", ack); end
        busStop();
        modelRx = 8'h3C;
        checks++; if (rx_data !== modelRx) begin failures++; $display("[TB] FAIL write_rx_data actual=%h required=%h", rx_data, modelRx); end
        checks++; if (rxCount - rx0 != 1) begin failures++; $display("[TB] FAIL write_rx_valid_count actual=%0d required=1", rxCount - rx0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL write_busy_clear actual=%b required=0", busy); end
    endtask

    task automatic test_wrong_addr();
        logic ack;
        int rx0 = rxCount;
        int oe0 = oeCount;
        busStart();
        writeByte(8'hA2, ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL wrong_addr_nack actual=%b required=1", ack); end
        writeByte(8'h55, ack);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL wrong_addr_busy actual=%b required=1", busy); end
        busStop();
        checks++; if (oeCount != oe0) begin failures++; $display("[TB] FAIL wrong_addr_sda_oe cycles=%0d required=0", oeCount - oe0); end
        checks++; if (rxCount != rx0) begin failures++; $display("[TB] FAIL wrong_addr_rx_valid actual=%0d required=0", rxCount - rx0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL wrong_addr_busy_clear actual=%b required=0", busy); end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] d;
        int tx0 = txReqCount;
        tx_data = 8'h96;
        busStart();
        writeByte(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL read_addr_ack actual=%b required=0", ack); end
        tx_data = 8'h5A;
        readByte(d, 1'b0);
        checks++; if (d !== 8'h96) begin failures++; $display("[TB] FAIL read_byte0 actual=%h required=96", d); end
        tx_data = 8'hE7;
        readByte(d, 1'b1);
        checks++; if (d !== 8'h5A) begin failures++; $display("[TB] FAIL read_byte1 actual=%h required=5a", d); end
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL read_release_after_nack actual=%b required=0", sda_oe); end
        busStop();
        checks++; if (txReqCount - tx0 != 2) begin failures++; $display("[TB] FAIL read_tx_req_count actual=%0d required=2", txReqCount - tx0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL read_busy_clear actual=%b required=0", busy); end
    endtask

    task automatic test_repeated_start();
        logic ack;
        logic [7:0] d;
        int tx0;
        int bf0;
        busStart();
        writeByte(8'hA0, ack);
        writeByte(8'h11, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL rs_data_ack actual=%b required=0", ack); end
        modelRx = 8'h11;
        tx0 = txReqCount;
        bf0 = busyFallCount;
        tx_data = 8'h3C;
        busStart();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rs_busy_held actual=%b required=1", busy); end
        writeByte(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL rs_read_addr_ack actual=%b required=0", ack); end
        checks++; if (txReqCount - tx0 != 1) begin failures++; $display("[TB] FAIL rs_tx_req actual=%0d required=1", txReqCount - tx0); end
        readByte(d, 1'b1);
        checks++; if (d !== 8'h3C) begin failures++; $display("[TB] FAIL rs_read_byte actual=%h required=3c", d); end
        checks++; if (busyFallCount != bf0) begin failures++; $display("[TB] FAIL rs_busy_dropped actual=%0d required=0", busyFallCount - bf0); end
        busStop();
        checks++; if (rx_data !== modelRx) begin failures++; $display("[TB] FAIL rs_rx_data actual=%h required=%h", rx_data, modelRx); end
    endtask

    task automatic test_stop_midbyte();
        logic ack;
        int rx0;
        int oe0;
        busStart();
        writeByte(8'hA0, ack);
        rx0 = rxCount;
        for (int i = 0; i < 4; i++) writeBit(1'b1);
        busStop();
        checks++; if (rxCount != rx0) begin failures++; $display("[TB] FAIL abort_rx_valid actual=%0d required=0", rxCount - rx0); end
        checks++; if (rx_data !== modelRx) begin failures++; $display("[TB] FAIL abort_rx_data actual=%h required=%h", rx_data, modelRx); end
        checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_outputs actual=oe%b/busy%b required=0/0", sda_oe, busy); end
        oe0 = oeCount;
        writeByte(8'hA0, ack);
        checks++; if (oeCount != oe0 || ack !== 1'b1) begin failures++; $display("[TB] FAIL abort_idle_ignores actual=oe_cycles%0d/ack%b required=0/1", oeCount - oe0, ack); end
    endtask

    task automatic test_reset_during_ack();
        logic ack;
        logic [7:0] d = 8'hC5;
        int oe0;
        busStart();
        writeByte(8'hA0, ack);
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        checks++; if (sda_oe !== 1'b1) begin failures++; $display("[TB] FAIL rst_ack_driven actual=%b required=1", sda_oe); end
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("[TB] FAIL rst_sda_oe_async actual=%b required=0", sda_oe); end
        checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || tx_req !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_outputs actual=%h/%b/%b/%b required=00/0/0/0", rx_data, rx_valid, tx_req, busy);
        end
        modelRx = 8'h00;
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        oe0 = oeCount;
        ctrlScl = 1'b1; #Q;
        ctrlScl = 1'b0; #Q;
        writeByte(8'h5A, ack);
        busStop();
        checks++; if (oeCount != oe0 || ack !== 1'b1) begin failures++; $display("[TB] FAIL rst_ignore_until_start actual=oe_cycles%0d/ack%b required=0/1", oeCount - oe0, ack); end
        busStart();
        writeByte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL rst_next_addr_ack actual=%b required=0", ack); end
        writeByte(8'h77, ack);
        busStop();
        modelRx = 8'h77;
        checks++; if (ack !== 1'b0 || rx_data !== modelRx) begin failures++; $display("[TB] FAIL rst_next_write actual=ack%b/%h required=0/%h", ack, rx_data, modelRx); end
    endtask

    task automatic test_random();
        logic ack;
        logic [7:0] d;
        logic [7:0] bytes[4];
        logic [6:0] addr;
        logic isRead;
        logic match;
        int n;
        int rx0;
        int tx0;
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 2) != 0) addr = DUT_ADDR;
            else begin
                addr = 7'($urandom_range(0, 127));
                while (addr == DUT_ADDR) addr = 7'($urandom_range(0, 127));
            end
            match = (addr == DUT_ADDR);
            isRead = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom_range(0, 255));
            rx0 = rxCount;
            tx0 = txReqCount;
            tx_data = bytes[0];
            busStart();
            writeByte({addr, isRead}, ack);
            checks++; if (ack !== !match) begin failures++; $display("[TB] FAIL rand%0d_addr_ack actual=%b required=%b", t, ack, !match); end
            for (int k = 0; k < n; k++) begin
                if (isRead) begin
                    tx_data = bytes[k + 1];
                    readByte(d, (k == n - 1));
                    checks++; if (d !== (match ? bytes[k] : 8'hFF)) begin
                        failures++; $display("[TB] FAIL rand%0d_read%0d actual=%h required=%h", t, k, d, match ? bytes[k] : 8'hFF);
                    end
                end else begin
                    writeByte(bytes[k], ack);
                    checks++; if (ack !== !match) begin failures++; $display("[TB] FAIL rand%0d_wr_ack%0d actual=%b required=%b", t, k, ack, !match); end
                    if (match) modelRx = bytes[k];
                end
            end
            busStop();
            if (isRead) begin
                checks++; if (txReqCount - tx0 != (match ? n : 0)) begin failures++; $display("[TB] FAIL rand%0d_tx_req actual=%0d required=%0d", t, txReqCount - tx0, match ? n : 0); end
            end else begin
                checks++; if (rxCount - rx0 != (match ? n : 0)) begin failures++; $display("[TB] FAIL rand%0d_rx_count actual=%0d required=%0d", t, rxCount - rx0, match ? n : 0); end
                if (match) begin
                    for (int k = 0; k < n; k++) begin
                        if (rx0 + k < rxLog.size()) begin
                            checks++; if (rxLog[rx0 + k] !== bytes[k]) begin failures++; $display("[TB] FAIL rand%0d_rx%0d actual=%h required=%h", t, k, rxLog[rx0 + k], bytes[k]); end
                        end
                    end
                end
            end
            checks++; if (rx_data !== modelRx || busy !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_end actual=%h/busy%b required=%h/0", t, rx_data, busy, modelRx); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read();
        test_repeated_start();
        test_stop_midbyte();
        test_reset_during_ack();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h50, the 7-bit bus address this block answers.
REQ-002 SHALL have port clk, input, 1, system clock; all logic is synchronous to its rising edge.
REQ-003 SHALL have port rst_, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port scl_in, input, 1, raw SCL pin level, asynchronous to clk.
REQ-005 SHALL have port sda_in, input, 1, raw SDA pin level, asynchronous to clk.
REQ-006 SHALL have port sda_oe, output, 1, 1 = pull SDA low (open drain), 0 = release.
REQ-007 SHALL have port rx_data, output, 8, last byte received in a write transfer.
REQ-008 SHALL have port rx_valid, output, 1, one-clk pulse when rx_data is updated.
REQ-009 SHALL have port tx_data, input, 8, next byte to send in a read transfer.
REQ-010 SHALL have port tx_req, output, 1, one-clk pulse requesting tx_data for the next read byte.
REQ-011 SHALL have port busy, output, 1, high from a detected START until a detected STOP.

Function
REQ-012 SHALL pass scl_in and sda_in through 2-flop synchronizers, with edge detection on the synchronized levels.
REQ-013 SHALL detect START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-014 SHALL sample data bits on SCL rising edges, MSB first, and change sda_oe only on SCL falling edges, except for the release rules in REQ-023.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-016 SHALL go to ADDR on START from any state; the bit counter is cleared to 0 on entry.
REQ-017 SHALL, in ADDR, shift 8 bits (7 address bits, then R/W); on a mismatch after bit 8 it SHALL go to WAIT_STOP without driving SDA.
REQ-018 SHALL, on an address match, assert sda_oe at the next SCL falling edge (ACK) and hold it for exactly one SCL period (ADDR_ACK).
REQ-019 SHALL, for R/W=0, go from ADDR_ACK to WR_DATA; after the 8th rising edge, load rx_data, pulse rx_valid for 1 clk, and ACK in WR_ACK as in REQ-018, then return to WR_DATA.
REQ-020 SHALL, for R/W=1, pulse tx_req on the clk of the SCL rising edge of ADDR_ACK or of an ACKed RD_ACK; tx_data is sampled at the following SCL falling edge.
REQ-021 SHALL, in RD_DATA, set sda_oe = ~bit at each SCL falling edge for 8 bits, then release SDA and sample the controller's ACK in RD_ACK.
REQ-022 SHALL, in RD_ACK, continue to RD_DATA with a new tx_req on ACK (0), and go to WAIT_STOP on NACK (1).
REQ-023 SHALL release sda_oe within 1 clk on any START or STOP, and SHALL go to IDLE on STOP from any state.
REQ-024 SHALL hold WAIT_STOP and IDLE with sda_oe=0 and no rx_valid/tx_req until START or STOP.
REQ-025 SHALL treat a STOP mid-byte as an abort: no rx_valid, and rx_data is unchanged.
REQ-026 SHALL set busy on START and clear it on STOP; a repeated START keeps busy high.
REQ-027 SHALL use a bit counter that wraps 7->0 at each byte boundary, with no state advance on the ACK bit other than those specified above.

Reset
REQ-028 SHALL, while rst_=0, force state IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0 and the bit counter to 0.
REQ-029 SHALL reset the synchronizer and edge-history flops to 1 (idle bus), so that deasserting reset generates no false START/STOP.
REQ-030 SHALL, after rst_ is deasserted mid-transfer, ignore bus activity until the next START.

Verification
REQ-031 Write to 0x50 (byte 0xA0, data 0x3C, STOP) -> ACK on address and data; rx_data=0x3C; exactly one rx_valid pulse; busy falls after STOP.
REQ-032 Write to 0x51 -> sda_oe stays 0 throughout; no rx_valid; busy 1 until STOP.
REQ-033 Read from 0x50 (0xA1), tx_data=0x96 then 0x5A, controller ACKs then NACKs -> SDA bits 10010110 then 01011010; two tx_req pulses; SDA released after NACK.
REQ-034 Repeated START after a write of 0x11 to 0x50, then read -> rx_data=0x11; busy stays 1; read phase entered with a tx_req pulse.
REQ-035 STOP after 4 bits of a data byte -> no rx_valid; state IDLE; sda_oe=0; busy=0.
REQ-036 rst_ pulsed low during the ACK of a write -> sda_oe=0 immediately; all outputs at reset values; the next valid write to 0x50 is ACKed normally.
